// File: rtl/sample_ram_pkg.sv
// Shared constants and FSM encoding for the sample RAM reader.
// CPU register map offsets and the read-path state type live here.
package sample_ram_pkg;

  localparam int NBANK_MAX = 8;

  localparam logic [11:0] ADDR_STATUS = 12'h800;
  localparam logic [11:0] ADDR_CLEAR  = 12'h801;
  localparam logic [11:0] ADDR_CNT    = 12'h810;
  localparam logic [11:0] ADDR_LAST   = 12'h820;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sample_bank_ram.sv
// Purpose: one sample bank, 2^AW x DW, loader write port plus CPU-side read port.
// Latency: read data valid one clock after rd_addr; a same-address write in that cycle returns the old byte.
// Backpressure: none; both ports accept every cycle.
module sample_bank_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          avs_clk,
  input  logic          wr_vld,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Loader write port; contents are never reset.
  always_ff @(posedge avs_clk) begin
    if (wr_vld) mem[wr_addr] <= wr_dat;
  end

  // Registered read port; sampling before the write lands gives old-data on collision.
  always_ff @(posedge avs_clk) begin
    rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_ram_reader.sv
// Purpose: captures loader writes into NBANK byte banks and serves data/fill status over Avalon-MM.
// Latency: data-window read returns 5 cycles after accept, register read 1 cycle, writes 1 cycle.
// Backpressure: reads stall via avs_waitrequest; loader capture is never stalled.
module sample_ram_reader
  import sample_ram_pkg::*;
#(
  parameter int NBANK = 6,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic                avs_clk,
  input  logic                avs_reset,
  input  logic [DW-1:0]       snk_writedata,
  input  logic [NBANK-1:0]    snk_cs,
  input  logic [NBANK-1:0]    snk_write,
  input  logic [NBANK*AW-1:0] snk_addr,
  input  logic                avs_cs,
  input  logic [11:0]         avs_addr,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic                avs_waitrequest
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_MAX = {1'b1, {AW{1'b0}}};

  logic [NBANK-1:0] snk_wr_vld;
  logic [NBANK-1:0] wr_flag;
  logic [CW-1:0]    wr_cnt    [NBANK];
  logic [AW-1:0]    last_addr [NBANK];
  logic [DW-1:0]    bank_rd_dat [NBANK];

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [4:0]  bank_q;
  logic [5:0]  word_q, word_sel;
  logic [1:0]  rd_byte;
  logic [AW-1:0] rd_addr;
  logic [31:0] shift_q, readdata_q, reg_rdata;
  logic [DW-1:0] rd_sel;
  logic        req_vld, accept, capture, reg_load, clr_hit;
  logic [NBANK_MAX-1:0] flag_pad;
  logic        unused_wdata;

  assign snk_wr_vld      = snk_cs & snk_write;
  assign req_vld         = avs_cs & avs_read;
  assign clr_hit         = avs_cs & avs_write & (avs_addr == ADDR_CLEAR);
  assign flag_pad        = NBANK_MAX'(wr_flag);
  assign avs_waitrequest = req_vld & (state_q != DONE);
  assign avs_readdata    = readdata_q;
  assign unused_wdata    = ^avs_writedata[31:NBANK];

  // One RAM read address is broadcast to every bank; the bank mux picks the result.
  assign rd_addr = AW'({word_sel, rd_byte});

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    sample_bank_ram #(.AW(AW), .DW(DW)) u_ram (
      .avs_clk (avs_clk),
      .wr_vld  (snk_wr_vld[b]),
      .wr_addr (snk_addr[b*AW +: AW]),
      .wr_dat  (snk_writedata),
      .rd_addr (rd_addr),
      .rd_dat  (bank_rd_dat[b])
    );
  end

  // Bank select for returned bytes; banks past NBANK read as zero.
  always_comb begin
    rd_sel = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (bank_q == 5'(b)) rd_sel = bank_rd_dat[b];
    end
  end

  // Register-space read decode; anything unmapped reads zero.
  always_comb begin
    reg_rdata = '0;
    if (avs_addr == ADDR_STATUS) reg_rdata = {23'h0, state_q != IDLE, flag_pad};
    for (int b = 0; b < NBANK; b++) begin
      if (avs_addr == ADDR_CNT  + 12'(b)) reg_rdata = 32'(wr_cnt[b]);
      if (avs_addr == ADDR_LAST + 12'(b)) reg_rdata = 32'(last_addr[b]);
    end
  end

  // Read FSM next state: byte 0 is requested in the accept cycle so four FETCH cycles collect all bytes.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    accept   = 1'b0;
    capture  = 1'b0;
    reg_load = 1'b0;
    word_sel = word_q;
    rd_byte  = 2'd0;
    case (state_q)
      IDLE: begin
        word_sel = avs_addr[5:0];
        if (req_vld) begin
          if (!avs_addr[11]) begin
            state_d = FETCH;
            k_d     = 2'd0;
            accept  = 1'b1;
          end else begin
            state_d  = DONE;
            reg_load = 1'b1;
          end
        end
      end
      FETCH: begin
        rd_byte = k_q + 2'd1;
        if (!req_vld) begin
          state_d = IDLE;
        end else begin
          capture = 1'b1;
          k_d     = k_q + 2'd1;
          if (k_q == 2'd3) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge avs_clk) begin
    if (avs_reset) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Read datapath: latch target, shift bytes in little-endian, publish on the last byte.
  always_ff @(posedge avs_clk) begin
    if (avs_reset) begin
      bank_q     <= '0;
      word_q     <= '0;
      shift_q    <= '0;
      readdata_q <= '0;
    end else begin
      if (accept) begin
        bank_q <= avs_addr[10:6];
        word_q <= avs_addr[5:0];
      end
      if (capture) begin
        shift_q <= {rd_sel, shift_q[31:8]};
        if (k_q == 2'd3) readdata_q <= {rd_sel, shift_q[31:8]};
      end
      if (reg_load) readdata_q <= reg_rdata;
    end
  end

  // Fill tracking per bank; a loader write beats a same-cycle CLEAR.
  always_ff @(posedge avs_clk) begin
    if (avs_reset) begin
      wr_flag <= '0;
      for (int b = 0; b < NBANK; b++) begin
        wr_cnt[b]    <= '0;
        last_addr[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (snk_wr_vld[b]) begin
          wr_flag[b]   <= 1'b1;
          last_addr[b] <= snk_addr[b*AW +: AW];
          if (clr_hit && avs_writedata[b])  wr_cnt[b] <= CW'(1);
          else if (wr_cnt[b] != CNT_MAX)    wr_cnt[b] <= wr_cnt[b] + CW'(1);
        end else if (clr_hit && avs_writedata[b]) begin
          wr_flag[b] <= 1'b0;
          wr_cnt[b]  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_ram_reader.sv
module tb_sample_ram_reader;

  localparam int NBANK = 6;
  localparam int AW    = 8;

  logic                clk = 1'b0;
  logic                avs_reset;
  logic [7:0]          snk_writedata;
  logic [NBANK-1:0]    snk_cs, snk_write;
  logic [NBANK*AW-1:0] snk_addr;
  logic                avs_cs, avs_read, avs_write;
  logic [11:0]         avs_addr;
  logic [31:0]         avs_writedata, avs_readdata;
  logic                avs_waitrequest;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bank contents and fill status.
  logic [7:0]       mem [NBANK][256];
  logic [NBANK-1:0] m_flag;
  int               m_cnt  [NBANK];
  int               m_last [NBANK];

  sample_ram_reader #(.NBANK(NBANK), .AW(AW), .DW(8)) dut (
    .avs_clk         (clk),
    .avs_reset       (avs_reset),
    .snk_writedata   (snk_writedata),
    .snk_cs          (snk_cs),
    .snk_write       (snk_write),
    .snk_addr        (snk_addr),
    .avs_cs          (avs_cs),
    .avs_addr        (avs_addr),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] exp_word(input logic [11:0] a);
    logic [31:0] r = '0;
    int bk, w;
    bk = int'(a[10:6]);
    w  = int'(a[5:0]);
    if (bk < NBANK) for (int n = 0; n < 4; n++) r[8*n +: 8] = mem[bk][w*4+n];
    return r;
  endfunction

  function automatic logic [31:0] exp_reg(input logic [11:0] a);
    logic [31:0] r = '0;
    if (a == 12'h800) r = {24'h0, 8'(m_flag)};
    for (int b = 0; b < NBANK; b++) begin
      if (a == 12'h810 + 12'(b)) r = 32'(m_cnt[b]);
      if (a == 12'h820 + 12'(b)) r = 32'(m_last[b]);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_flag = '0;
    for (int b = 0; b < NBANK; b++) begin m_cnt[b] = 0; m_last[b] = 0; end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // One loader cycle (optionally with a CPU CLEAR), then the model update: clear first, then writes.
  task automatic step_cycle(input logic [NBANK-1:0] cs, input logic [NBANK-1:0] wr,
                            input logic [NBANK*AW-1:0] addrs, input logic [7:0] data,
                            input logic clr, input logic [31:0] clr_data);
    logic [7:0] a;
    snk_cs = cs; snk_write = wr; snk_addr = addrs; snk_writedata = data;
    if (clr) begin avs_cs = 1'b1; avs_write = 1'b1; avs_addr = 12'h801; avs_writedata = clr_data; end
    cyc();
    snk_cs = '0; snk_write = '0;
    if (clr) begin avs_cs = 1'b0; avs_write = 1'b0; end
    for (int b = 0; b < NBANK; b++)
      if (clr && clr_data[b]) begin m_flag[b] = 1'b0; m_cnt[b] = 0; end
    for (int b = 0; b < NBANK; b++) begin
      if (cs[b] && wr[b]) begin
        a = addrs[b*AW +: AW];
        mem[b][a] = data;
        m_flag[b] = 1'b1;
        if (m_cnt[b] < 256) m_cnt[b]++;
        m_last[b] = int'(a);
      end
    end
  endtask

  task automatic load(input int b, input int a, input logic [7:0] d);
    logic [NBANK*AW-1:0] ad = '0;
    ad[b*AW +: AW] = AW'(a);
    step_cycle(NBANK'(1) << b, NBANK'(1) << b, ad, d, 1'b0, 32'h0);
  endtask

  task automatic wait_done(output int waits);
    waits = 0;
    #1;
    while (avs_waitrequest === 1'b1 && waits < 20) begin @(posedge clk); #2; waits++; end
    if (waits >= 20) waits = -1;
  endtask

  task automatic cpu_read(input logic [11:0] a, output logic [31:0] d, output int waits);
    avs_cs = 1'b1; avs_read = 1'b1; avs_addr = a;
    wait_done(waits);
    d = avs_readdata;
    avs_cs = 1'b0; avs_read = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    logic [31:0] d; int w;
    avs_reset = 1'b1;
    repeat (3) cyc();
    n_checks++; if (avs_readdata !== 32'h0) $display("FAIL rst_readdata: got %h want 0", avs_readdata); else n_pass++;
    n_checks++; if (avs_waitrequest !== 1'b0) $display("FAIL rst_waitreq: got %b want 0", avs_waitrequest); else n_pass++;
    avs_reset = 1'b0;
    model_reset();
    cyc();
    cpu_read(12'h800, d, w);
    n_checks++; if (d !== 32'h0) $display("FAIL rst_status: got %h want 0", d); else n_pass++;
    n_checks++; if (w !== 1) $display("FAIL rst_reg_wait: got %0d want 1", w); else n_pass++;
    cpu_read(12'h810, d, w);
    n_checks++; if (d !== 32'h0) $display("FAIL rst_cnt0: got %h want 0", d); else n_pass++;
    cpu_read(12'h820, d, w);
    n_checks++; if (d !== 32'h0) $display("FAIL rst_last0: got %h want 0", d); else n_pass++;
  endtask

  task automatic test_bank_read();
    logic [31:0] d; int w;
    for (int i = 0; i < 4; i++) load(2, i, 8'h10 + 8'(i));
    cpu_read(12'h080, d, w);
    n_checks++; if (d !== 32'h13121110) $display("FAIL t1_data: got %h want 13121110", d); else n_pass++;
    n_checks++; if (w !== 5) $display("FAIL t1_waits: got %0d want 5", w); else n_pass++;
  endtask

  task automatic test_multi_bank();
    logic [31:0] d; int w;
    logic [NBANK*AW-1:0] ad = '0;
    step_cycle('0, '0, '0, 8'h0, 1'b1, 32'hFF);
    ad[0*AW +: AW] = 8'h07;
    ad[5*AW +: AW] = 8'h3C;
    step_cycle(6'b100001, 6'b100001, ad, 8'hA5, 1'b0, 32'h0);
    cpu_read(12'h800, d, w);
    n_checks++; if (d !== 32'h21) $display("FAIL t2_status: got %h want 21", d); else n_pass++;
    cpu_read(12'h810, d, w);
    n_checks++; if (d !== 32'h1) $display("FAIL t2_cnt0: got %h want 1", d); else n_pass++;
    cpu_read(12'h815, d, w);
    n_checks++; if (d !== 32'h1) $display("FAIL t2_cnt5: got %h want 1", d); else n_pass++;
    cpu_read(12'h825, d, w);
    n_checks++; if (d !== 32'h3C) $display("FAIL t2_last5: got %h want 3c", d); else n_pass++;
    cpu_read(12'h14F, d, w);
    n_checks++; if (d[7:0] !== 8'hA5) $display("FAIL t2_byte: got %h want a5", d[7:0]); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [31:0] d; int w;
    for (int i = 0; i < 300; i++) load(1, i % 256, 8'($urandom));
    cpu_read(12'h811, d, w);
    n_checks++; if (d !== 32'd256) $display("FAIL t3_cnt_sat: got %0d want 256", d); else n_pass++;
    cpu_read(12'h821, d, w);
    n_checks++; if (d !== 32'd43) $display("FAIL t3_last: got %0d want 43", d); else n_pass++;
    step_cycle('0, '0, '0, 8'h0, 1'b1, 32'h02);
    cpu_read(12'h800, d, w);
    n_checks++; if (d !== 32'h21) $display("FAIL t3_status_clr: got %h want 21", d); else n_pass++;
    cpu_read(12'h811, d, w);
    n_checks++; if (d !== 32'h0) $display("FAIL t3_cnt_clr: got %h want 0", d); else n_pass++;
  endtask

  task automatic test_clear_collision();
    logic [31:0] d; int w;
    logic [NBANK*AW-1:0] ad = '0;
    load(3, 5, 8'h55);
    load(3, 6, 8'h66);
    ad[3*AW +: AW] = 8'h07;
    step_cycle(6'b001000, 6'b001000, ad, 8'h77, 1'b1, 32'h08);
    cpu_read(12'h800, d, w);
    n_checks++; if (d[3] !== 1'b1) $display("FAIL t4_flag3: got %b want 1", d[3]); else n_pass++;
    cpu_read(12'h813, d, w);
    n_checks++; if (d !== 32'h1) $display("FAIL t4_cnt3: got %h want 1", d); else n_pass++;
    cpu_read(12'h823, d, w);
    n_checks++; if (d !== 32'h7) $display("FAIL t4_last3: got %h want 7", d); else n_pass++;
  endtask

  task automatic test_read_during_write();
    logic [31:0] d, expd; int w;
    for (int i = 0; i < 4; i++) load(4, i, 8'hB0 + 8'(i));
    expd = exp_word(12'h100);
    avs_cs = 1'b1; avs_read = 1'b1; avs_addr = 12'h100;
    cyc();
    load(4, 1, 8'hEE);
    wait_done(w);
    d = avs_readdata;
    avs_cs = 1'b0; avs_read = 1'b0;
    cyc();
    n_checks++; if (d !== expd) $display("FAIL t5_old_byte: got %h want %h", d, expd); else n_pass++;
    cpu_read(12'h100, d, w);
    n_checks++; if (d !== 32'hB3B2EEB0) $display("FAIL t5_new_byte: got %h want b3b2eeb0", d); else n_pass++;
    cpu_read(12'h180, d, w);
    n_checks++; if (d !== 32'h0) $display("FAIL t5_bank6: got %h want 0", d); else n_pass++;
    n_checks++; if (w !== 5) $display("FAIL t5_bank6_wait: got %0d want 5", w); else n_pass++;
    cpu_read(12'h7FF, d, w);
    n_checks++; if (d !== 32'h0) $display("FAIL t5_bank31: got %h want 0", d); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] d; int w;
    avs_cs = 1'b1; avs_read = 1'b1; avs_addr = 12'h080;
    cyc();
    cyc();
    avs_reset = 1'b1;
    cyc();
    n_checks++; if (avs_readdata !== 32'h0) $display("FAIL t6_rst_readdata: got %h want 0", avs_readdata); else n_pass++;
    avs_reset = 1'b0;
    model_reset();
    wait_done(w);
    d = avs_readdata;
    avs_cs = 1'b0; avs_read = 1'b0;
    cyc();
    n_checks++; if (w !== 5) $display("FAIL t6_restart_wait: got %0d want 5", w); else n_pass++;
    n_checks++; if (d !== 32'h13121110) $display("FAIL t6_ram_kept: got %h want 13121110", d); else n_pass++;
    cpu_read(12'h800, d, w);
    n_checks++; if (d !== 32'h0) $display("FAIL t6_status: got %h want 0", d); else n_pass++;
    cpu_read(12'h812, d, w);
    n_checks++; if (d !== 32'h0) $display("FAIL t6_cnt2: got %h want 0", d); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] d, expd; int w, expw;
    logic [11:0] a;
    logic [NBANK*AW-1:0] ad;
    for (int b = 0; b < NBANK; b++)
      for (int i = 0; i < 256; i++) load(b, i, 8'($urandom));
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) begin
        ad = (NBANK*AW)'({$urandom(), $urandom()});
        step_cycle(NBANK'($urandom()), NBANK'($urandom()), ad, 8'($urandom()),
                   $urandom_range(0, 5) == 0, $urandom());
      end
      if ($urandom_range(0, 3) == 0) a = 12'h800 + 12'($urandom_range(0, 47));
      else a = {1'b0, 5'($urandom_range(0, 7)), 6'($urandom_range(0, 63))};
      expd = a[11] ? exp_reg(a) : exp_word(a);
      expw = a[11] ? 1 : 5;
      cpu_read(a, d, w);
      n_checks++; if (d !== expd) $display("FAIL rnd_data @%h: got %h want %h", a, d, expd); else n_pass++;
      n_checks++; if (w !== expw) $display("FAIL rnd_wait @%h: got %0d want %0d", a, w, expw); else n_pass++;
    end
  endtask

  initial begin
    avs_reset = 1'b1; snk_writedata = '0; snk_cs = '0; snk_write = '0; snk_addr = '0;
    avs_cs = 1'b0; avs_read = 1'b0; avs_write = 1'b0; avs_addr = '0; avs_writedata = '0;
    test_reset();
    test_bank_read();
    test_multi_bank();
    test_saturation();
    test_clear_collision();
    test_read_during_write();
    test_reset_mid_fetch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
